m_div_sequencer: RTL

- Iterative restoring divider for the M-extension coprocessor: own R/D/Z registers plus a control FSM.
- Executes DIV, DIVU, REM and REMU, one quotient bit per cycle.
- The PCPI-facing M controller launches it with a start/done handshake and reads the result.
- Handles divide-by-zero and signed overflow via a short path, per the RISC-V spec.

---
 rtl/m_div_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/m_div_sequencer.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) for the M coprocessor.
// Ports: clk, reset (async, active-high); start/op/dividend/divisor in; busy/done/result out.
module m_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIXUP,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] r;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] z;
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            neg_r;

  logic            signed_op;
  logic            div_zero;
  logic            ovf;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN:0]   t_r;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  assign signed_op = ~op_q[0];
  assign div_zero  = (b_q == '0);
  assign ovf       = signed_op
                   && (a_q == {1'b1, {(XLEN-1){1'b0}}})
                   && (b_q == '1);

  assign a_neg = signed_op & a_q[XLEN-1];
  assign b_neg = signed_op & b_q[XLEN-1];
  assign a_abs = a_neg ? -a_q : a_q;
  assign b_abs = b_neg ? -b_q : b_q;

  // {R,Z} << 1; the top bit of the subtraction is the borrow.
  assign t_r  = {r, z[XLEN-1]};
  assign diff = t_r - {1'b0, d};
  assign ge   = ~diff[XLEN];

  assign quo = neg_q ? -z : z;
  assign rem = neg_r ? -r : r;

  assign busy = (state == SETUP) || (state == ITER) || (state == FIXUP);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   state_nx = (div_zero || ovf) ? DONE : ITER;
      ITER:    if (cnt == '0) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r      <= '0;
      d      <= '0;
      z      <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= dividend;
            b_q  <= divisor;
          end
        end
        SETUP: begin
          if (div_zero) begin
            result <= op_q[1] ? a_q : '1;
          end else if (ovf) begin
            result <= op_q[1] ? '0 : a_q;
          end else begin
            z     <= a_abs;
            d     <= b_abs;
            r     <= '0;
            cnt   <= CW'(XLEN - 1);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
          end
        end
        ITER: begin
          r   <= ge ? diff[XLEN-1:0] : t_r[XLEN-1:0];
          z   <= {z[XLEN-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        FIXUP: begin
          result <= op_q[1] ? rem : quo;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
